bidir_bus: RTL and testbench
============================

// Module: bidir_bus
// PURPOSE
//   Single-port tri-state bus transceiver with bus parking. Local logic sends a word onto a shared
//   inout bus and later reads a word back from it. Sits between a local data path and a
//   multi-drop 8-bit bus. After a send, the block keeps driving the bus with the last sent word.
//   It releases the bus only at a receive (turnaround), so a read-back always sees defined data.
// PARAMETERS
//   DATA_W   8   width of data_to_bus, data_from_bus and bus_data
// PORTS
//   clk            in     1       rising-edge clock; the only clock
//   rst_n          in     1       reset, asynchronous assert, active-low
//   send           in     1       load data_to_bus and take bus ownership (sampled at clk)
//   data_to_bus    in     DATA_W  word to place on the bus
//   rcv            in     1       capture bus_data and release ownership (sampled at clk)
//   data_from_bus  out    DATA_W  last captured bus word (registered)
//   bus_data       inout  DATA_W  shared tri-state bus
//   rx_valid       out    1       only with BIDIR_BUS_RX_STROBE_EN
// BEHAVIOUR
//   - Single clock clk; reset is asynchronous and active-low (rst_n).
//   - Registers: tx_q[DATA_W], own_q, rx_q[DATA_W].
//   - Reset (rst_n=0, any time, including mid-transfer): tx_q=0, own_q=0, rx_q=0.
//     data_from_bus=0, bus_data='z immediately (asynchronous, not clock-gated).
//   - Drive: bus_data = own_q ? tx_q : 'z. Purely combinational from flops, no other drive path.
//   - send=1 at edge: tx_q<=data_to_bus, own_q<=1. Bus shows the new word one edge after send.
//   - send=0 does NOT release the bus. own_q and tx_q hold (parking), and bus keeps last word.
//   - rcv=1 at edge: rx_q<=bus_data (pre-edge bus value), own_q<=0 unless send=1 at that edge.
//     data_from_bus updates one edge after rcv. If owned, the captured word is tx_q (loopback).
//     If not owned, the captured word is whatever the external driver presents.
//   - send=1 and rcv=1 at same edge: rx_q captures the old bus value, tx_q loads the new word,
//     and own_q stays 1 (send wins ownership).
//   - Neither asserted: all registers hold.
//   - Back-to-back sends: each edge overwrites tx_q. There is no queueing.
//   - data_from_bus holds its value until the next rcv edge or reset.
//   - Capturing a floating bus (rcv with no owner and no external driver) is legal.
//     The captured value is undefined; the block does no Z/X detection.
// CONFIGURATION
//   BIDIR_BUS_RX_STROBE_EN defined: adds output rx_valid.
//     rx_valid is a registered 1-cycle pulse, high in the cycle after each rcv edge; reset 0.
//   Not defined: no rx_valid port. All other behaviour is identical.
// STRUCTURE
//   Package bidir_bus_pkg: DATA_W default (8), localparam BUS_IDLE='z, reset constants
//   (TX_RST=0, RX_RST=0).
//   Sub-module bidir_bus_iobuf: DATA_W-wide tri-state driver.
//     Ports: oe, dout, io. Combinational only.
//   Top: bidir_bus holds the tx/own/rx flops and instantiates one bidir_bus_iobuf.
// TESTING
//   1 Reset: rst_n=0 mid-run -> bus_data='z, data_from_bus=8'h00, no clk edge needed.
//   2 Send then read-back: send=1,data_to_bus=8'hA5 one edge; send=0 two edges;
//     bus_data stays 8'hA5. rcv=1 one edge -> data_from_bus=8'hA5 and bus_data='z after it.
//   3 External read: no ownership, tb drives bus_data=8'h3C, rcv one edge
//     -> data_from_bus=8'h3C, DUT never drives the bus (no contention X).
//   4 Simultaneous: own with 8'h11, then send=1 data_to_bus=8'h22 with rcv=1
//     -> data_from_bus=8'h11, bus_data=8'h22 and still driven.
//   5 Overwrite: sends 8'h01 then 8'hFF on consecutive edges -> bus_data=8'hFF; read-back 8'hFF.
//   6 With BIDIR_BUS_RX_STROBE_EN: rcv at edge N -> rx_valid=1 exactly cycle N..N+1 only.

Source files
------------

// File: rtl/bidir_bus_pkg.sv
// Shared constants for the bidir_bus tri-state transceiver: default width, idle bus level
// and register reset values.
package bidir_bus_pkg;

    localparam int unsigned DEF_DATA_W = 8;

    // Single-bit idle level, replicated to bus width where used
    localparam logic BUS_IDLE = 1'bz;

    localparam logic [DEF_DATA_W-1:0] TX_RST = '0;
    localparam logic [DEF_DATA_W-1:0] RX_RST = '0;

endpackage

// File: rtl/bidir_bus_iobuf.sv
// Width-configurable tri-state driver: drives dout onto io while oe is high, else releases it.
module bidir_bus_iobuf
    import bidir_bus_pkg::*;
#(
    parameter int unsigned Width = DEF_DATA_W
) (
    input  logic             oe,
    input  logic [Width-1:0] dout,
    inout  wire  [Width-1:0] io
);

    assign io = oe ? dout : {Width{BUS_IDLE}};

endmodule

// File: rtl/bidir_bus.sv
// Tri-state bus transceiver with bus parking: the last sent word stays on the bus until a receive.
// Optional rx_valid strobe is enabled by defining BIDIR_BUS_RX_STROBE_EN.
module bidir_bus
    import bidir_bus_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] data_to_bus,
    input  logic              rcv,
    output logic [DATA_W-1:0] data_from_bus,
    inout  wire  [DATA_W-1:0] bus_data
`ifdef BIDIR_BUS_RX_STROBE_EN
    ,
    output logic              rx_valid
`endif
);

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              own_q, own_d;

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        own_d = own_q;
        if (rcv) begin
            rx_d  = bus_data;
            own_d = 1'b0;
        end
        // A simultaneous send keeps ownership; the capture still sees the old bus word
        if (send) begin
            tx_d  = data_to_bus;
            own_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q  <= DATA_W'(TX_RST);
            rx_q  <= DATA_W'(RX_RST);
            own_q <= 1'b0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            own_q <= own_d;
        end
    end

    assign data_from_bus = rx_q;

    bidir_bus_iobuf #(
        .Width (DATA_W)
    ) u_iobuf (
        .oe   (own_q),
        .dout (tx_q),
        .io   (bus_data)
    );

`ifdef BIDIR_BUS_RX_STROBE_EN
    logic rx_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rcv;
        end
    end

    assign rx_valid = rx_valid_q;
`endif

endmodule

// File: tb/tb_bidir_bus.sv
// Directed bench for bidir_bus: parking, loopback read, external read, send/rcv collision,
// overwrite and asynchronous reset. Bus release is probed by driving a pattern from the bench.
module tb_bidir_bus;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       send;
    logic [7:0] data_to_bus;
    logic       rcv;
    logic [7:0] data_from_bus;
    wire  [7:0] bus_data;
    logic       tb_oe;
    logic [7:0] tb_dout;
`ifdef BIDIR_BUS_RX_STROBE_EN
    logic       rx_valid;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    assign bus_data = tb_oe ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    bidir_bus #(
        .DATA_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .send          (send),
        .data_to_bus   (data_to_bus),
        .rcv           (rcv),
        .data_from_bus (data_from_bus),
        .bus_data      (bus_data)
`ifdef BIDIR_BUS_RX_STROBE_EN
        ,
        .rx_valid      (rx_valid)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a probe word from the bench; if the DUT still drives, the bus will not read back clean
    task automatic probe_released(input string tag, input logic [7:0] pattern);
        tb_dout = pattern;
        tb_oe   = 1'b1;
        #1;
        check(tag, bus_data, pattern);
        tb_oe   = 1'b0;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        send        = 1'b0;
        rcv         = 1'b0;
        data_to_bus = 8'h00;
        tb_oe       = 1'b0;
        tb_dout     = 8'h00;

        // Reset state
        step();
        step();
        check("reset_dfb", data_from_bus, 8'h00);
`ifdef BIDIR_BUS_RX_STROBE_EN
        check("reset_rx_valid", {7'b0, rx_valid}, 8'h00);
`endif
        probe_released("reset_bus_idle", 8'h5A);
        rst_n = 1'b1;
        step();

        // Send then parked read-back
        send        = 1'b1;
        data_to_bus = 8'hA5;
        step();
        send        = 1'b0;
        data_to_bus = 8'h00;
        check("send_a5_bus", bus_data, 8'hA5);
        step();
        check("park1_bus", bus_data, 8'hA5);
        step();
        check("park2_bus", bus_data, 8'hA5);
        rcv = 1'b1;
        step();
        rcv = 1'b0;
        check("loopback_dfb", data_from_bus, 8'hA5);
`ifdef BIDIR_BUS_RX_STROBE_EN
        check("rx_valid_high", {7'b0, rx_valid}, 8'h01);
`endif
        probe_released("rcv_releases_bus", 8'h5A);
        step();
        check("dfb_holds", data_from_bus, 8'hA5);
`ifdef BIDIR_BUS_RX_STROBE_EN
        check("rx_valid_low", {7'b0, rx_valid}, 8'h00);
`endif

        // External driver read, DUT must stay off the bus
        tb_dout = 8'h3C;
        tb_oe   = 1'b1;
        #1;
        check("ext_no_contention", bus_data, 8'h3C);
        rcv = 1'b1;
        step();
        rcv = 1'b0;
        check("ext_read_dfb", data_from_bus, 8'h3C);
        check("ext_bus_after", bus_data, 8'h3C);
        tb_oe = 1'b0;
        #1;

        // Simultaneous send and rcv
        send        = 1'b1;
        data_to_bus = 8'h11;
        step();
        check("own_11_bus", bus_data, 8'h11);
        data_to_bus = 8'h22;
        rcv         = 1'b1;
        step();
        send = 1'b0;
        rcv  = 1'b0;
        check("simul_dfb_old", data_from_bus, 8'h11);
        check("simul_bus_new", bus_data, 8'h22);
        step();
        check("simul_still_driven", bus_data, 8'h22);

        // Back-to-back overwrite
        send        = 1'b1;
        data_to_bus = 8'h01;
        step();
        data_to_bus = 8'hFF;
        step();
        send = 1'b0;
        check("overwrite_bus", bus_data, 8'hFF);
        rcv = 1'b1;
        step();
        rcv = 1'b0;
        check("overwrite_dfb", data_from_bus, 8'hFF);

        // Asynchronous reset mid-run while owning the bus
        send        = 1'b1;
        data_to_bus = 8'h77;
        step();
        send = 1'b0;
        check("pre_reset_bus", bus_data, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_dfb", data_from_bus, 8'h00);
        probe_released("async_reset_bus", 8'h5A);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_dfb", data_from_bus, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
